restoring_div_ctrl: RTL and testbench

- FSM that sequences an N-bit restoring divider datapath: accumulator A, quotient/dividend Q, divisor M.
- Issues one-hot control strobes per cycle: load, clear, shift-left {A,Q}, subtract, restore, set Q0.
- Counts WIDTH iterations, detects divide-by-zero, and gives the requester a start/busy/done handshake.
- Sits beside the divider datapath and is driven by the top-level divider wrapper.

---
 rtl/div_pkg.sv | 26 ++
 rtl/restoring_div_ctrl.sv | 127 ++++++++++++
 tb/tb_restoring_div_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divider controller and datapath.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHK0  = 3'd2,
    S_SHIFT = 3'd3,
    S_SUB   = 3'd4,
    S_TEST  = 3'd5,
    S_DONE  = 3'd6
  } div_state_e;

  function automatic logic state_is_busy(input div_state_e s);
    logic b;
    case (s)
      S_LOAD, S_CHK0, S_SHIFT, S_SUB, S_TEST: b = 1'b1;
      default:                                b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/restoring_div_ctrl.sv
// Sequencer for an N-bit restoring divider: issues one datapath strobe per
// cycle, counts iterations, flags divide-by-zero and handles start/busy/done.
module restoring_div_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             divisor_zero,
  input  logic             a_msb,
  output logic             ld_inputs,
  output logic             clr_a,
  output logic             shift_aq,
  output logic             sub_en,
  output logic             restore,
  output logic             set_q0,
  output logic             busy,
  output logic             done,
  output logic             err_div0,
  output logic [CNT_W-1:0] iter_cnt
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // State, iteration counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter and flag computation; start is only honoured when idle or done.
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = {CNT_W{1'b0}};
        err_d   = 1'b0;
        state_d = start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        cnt_d   = CNT_W'(WIDTH);
        err_d   = 1'b0;
        state_d = S_CHK0;
      end
      S_CHK0: begin
        if (divisor_zero) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          err_d   = err_q;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: state_d = S_SUB;
      S_SUB:   state_d = S_TEST;
      S_TEST: begin
        // A zero count here cannot occur in normal flow; finish rather than wrap.
        if (cnt_q > CNT_W'(1)) begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = S_SHIFT;
        end else begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = start ? S_LOAD : S_DONE;
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  // Strobe decode from the state register; TEST picks restore or set_q0 from the sign of A.
  always_comb begin
    ld_inputs = 1'b0;
    clr_a     = 1'b0;
    shift_aq  = 1'b0;
    sub_en    = 1'b0;
    restore   = 1'b0;
    set_q0    = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_inputs = 1'b1;
        clr_a     = 1'b1;
      end
      S_SHIFT: shift_aq = 1'b1;
      S_SUB:   sub_en   = 1'b1;
      S_TEST: begin
        if (a_msb) begin
          restore = 1'b1;
        end else begin
          set_q0 = 1'b1;
        end
      end
      default: begin
        ld_inputs = 1'b0;
        clr_a     = 1'b0;
      end
    endcase
  end

  assign busy     = state_is_busy(state_q);
  assign done     = done_q;
  assign err_div0 = err_q;
  assign iter_cnt = cnt_q;

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Directed bench: controller paired with a behavioural restoring-divider datapath.
module tb_restoring_div_ctrl;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          divisor_zero;
  logic          a_msb;
  logic          ld_inputs, clr_a, shift_aq, sub_en, restore, set_q0;
  logic          busy, done, err_div0;
  logic [CW-1:0] iter_cnt;

  logic [W:0]   a_m = '0;
  logic [W-1:0] q_m = '0;
  logic [W-1:0] m_m = '0;
  logic [W-1:0] dividend, divisor;
  int n_shift = 0, n_sub = 0, n_rest = 0, n_set = 0, n_multi = 0;
  int n_vec = 0, n_bad = 0;

  restoring_div_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .divisor_zero(divisor_zero), .a_msb(a_msb),
    .ld_inputs(ld_inputs), .clr_a(clr_a), .shift_aq(shift_aq),
    .sub_en(sub_en), .restore(restore), .set_q0(set_q0),
    .busy(busy), .done(done), .err_div0(err_div0), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  assign divisor_zero = (m_m == '0);
  assign a_msb        = a_m[W];

  // Behavioural datapath plus strobe counters.
  always @(posedge clk) begin
    if (ld_inputs) begin
      q_m <= dividend;
      m_m <= divisor;
      n_shift <= 0; n_sub <= 0; n_rest <= 0; n_set <= 0;
    end
    if (clr_a) a_m <= '0;
    if (shift_aq) begin
      a_m <= {a_m[W-1:0], q_m[W-1]};
      q_m <= {q_m[W-2:0], 1'b0};
      n_shift <= n_shift + 1;
    end
    if (sub_en) begin
      a_m <= a_m - {1'b0, m_m};
      n_sub <= n_sub + 1;
    end
    if (restore) begin
      a_m <= a_m + {1'b0, m_m};
      n_rest <= n_rest + 1;
    end
    if (set_q0) begin
      q_m[0] <= 1'b1;
      n_set <= n_set + 1;
    end
    if (!ld_inputs && (int'(clr_a) + int'(shift_aq) + int'(sub_en) + int'(restore) + int'(set_q0)) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input int exp_q, input int exp_r,
                         input int exp_set, input int exp_rest, input bit repulse);
    int edges;
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("load_busy", 32'(busy), 32'd1);
    edges = 0;
    while (!done && edges < 100) begin
      start = repulse && (edges == 5 || edges == 15);
      tick();
      edges++;
      if (edges == 1) check("cnt_init", 32'(iter_cnt), 32'(W));
    end
    start = 1'b0;
    check("latency", 32'(edges), 32'd26);
    check("quotient", 32'(q_m), 32'(exp_q));
    check("remainder", 32'(a_m[W-1:0]), 32'(exp_r));
    check("n_shift", 32'(n_shift), 32'(W));
    check("n_sub", 32'(n_sub), 32'(W));
    check("n_set_q0", 32'(n_set), 32'(exp_set));
    check("n_restore", 32'(n_rest), 32'(exp_rest));
    check("err_div0", 32'(err_div0), 32'd0);
    check("busy_done", 32'(busy), 32'd0);
    check("cnt_done", 32'(iter_cnt), 32'd0);
  endtask

  initial begin
    int first_e, second_e, ndone;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_div0), 32'd0);
    check("rst_cnt", 32'(iter_cnt), 32'd0);
    check("rst_strobes", 32'({ld_inputs, clr_a, shift_aq, sub_en, restore, set_q0}), 32'd0);
    rst_n = 1'b1;
    tick();

    run_div(8'd13, 8'd4, 3, 1, 2, 6, 1'b0);
    repeat (3) tick();
    check("done_held", 32'(done), 32'd1);
    run_div(8'd255, 8'd1, 255, 0, 8, 0, 1'b0);
    run_div(8'd7, 8'd9, 0, 7, 0, 8, 1'b0);

    // Divide by zero: done is up by edge 3 with no iteration strobes.
    dividend = 8'd50;
    divisor  = 8'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("div0_early", 32'(done), 32'd0);
    tick();
    tick();
    check("div0_done", 32'(done), 32'd1);
    check("div0_err", 32'(err_div0), 32'd1);
    check("div0_busy", 32'(busy), 32'd0);
    check("div0_shift", 32'(n_shift), 32'd0);
    check("div0_sub", 32'(n_sub), 32'd0);
    run_div(8'd20, 8'd5, 4, 0, 1, 7, 1'b0);

    run_div(8'd100, 8'd7, 14, 2, 3, 5, 1'b1);

    // Asynchronous abort mid-division.
    dividend = 8'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_cnt", 32'(iter_cnt), 32'd0);
    check("abort_strobes", 32'({ld_inputs, clr_a, shift_aq, sub_en, restore, set_q0}), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    run_div(8'd9, 8'd3, 3, 0, 2, 6, 1'b0);

    // start held high: one DONE cycle between back-to-back divisions.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    first_e  = -1;
    second_e = -1;
    ndone    = 0;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (done) begin
        ndone++;
        if (first_e < 0) first_e = e;
        else if (second_e < 0) second_e = e;
        check("held_q", 32'(q_m), 32'd14);
      end
    end
    start = 1'b0;
    check("held_first", 32'(first_e), 32'd26);
    check("held_second", 32'(second_e), 32'd53);
    check("held_ndone", 32'(ndone), 32'd2);
    check("one_hot", 32'(n_multi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
